audio_pitch_detector: RTL and testbench

AUDIO_PITCH_DETECTOR -- requirements
Module: audio_pitch_detector

---
 rtl/audio_pitch_if.sv | 29 ++
 rtl/audio_pitch_detector.sv | 168 ++++++++++++++++
 tb/tb_audio_pitch_detector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pitch_if.sv
// audio_pitch_if: sample-FIFO handshake from the audio controller plus the
// pitch measurement results, bundled as one port.
// master = audio controller / consumer side, slave = pitch detector side.
interface audio_pitch_if;
    logic               audio_in_available;
    logic signed [31:0] left_channel_audio_in;
    logic               read_audio_in;
    logic [15:0]        period;
    logic               period_valid;
    logic               locked;

    modport master (
        output audio_in_available,
        output left_channel_audio_in,
        input  read_audio_in,
        input  period,
        input  period_valid,
        input  locked
    );

    modport slave (
        input  audio_in_available,
        input  left_channel_audio_in,
        output read_audio_in,
        output period,
        output period_valid,
        output locked
    );
endinterface

// File: rtl/audio_pitch_detector.sv
// audio_pitch_detector: measures the period (in samples) of the left audio
// channel from hysteresis-qualified rising crossings, with glitch rejection
// below MIN_PERIOD and loss of lock after MAX_PERIOD samples without a crossing.
// Optional feature macro: PITCH_AVG4_EN -- report the truncated mean of the
// last four raw periods instead of each raw period.
module audio_pitch_detector #(
    parameter logic signed [31:0] HYST       = 32'sd2000000,
    parameter logic [15:0]        MIN_PERIOD = 16'd8,
    parameter logic [15:0]        MAX_PERIOD = 16'd4800
) (
    input logic          CLOCK_50,
    input logic          reset,
    audio_pitch_if.slave aud
);
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        S_UNK  = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] sample_p0;
    logic                     accept_p0;
    logic                     is_high_p0;
    logic                     is_low_p0;
    logic [CNT_W-1:0]         sample_cnt;
    logic [CNT_W-1:0]         cnt_plus1;
    logic                     timeout;
    logic                     rise;
    logic                     lock_acq;
    logic                     period_ok;
    logic                     counted;
    logic                     locked_p1;
    logic                     vld_p1;
    logic [CNT_W-1:0]         period_p1;
    logic                     report_ready;
    logic [CNT_W-1:0]         period_new;

    // Counter step that never passes MAX_PERIOD
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= MAX_PERIOD)
            return MAX_PERIOD;
        return cnt + 16'd1;
    endfunction

    // Stage p0: sample acceptance and hysteresis classification
    assign accept_p0         = aud.audio_in_available & ~reset;
    assign aud.read_audio_in = accept_p0;
    assign sample_p0         = aud.left_channel_audio_in;
    assign is_high_p0        = sample_p0 > HYST;
    assign is_low_p0         = sample_p0 < -HYST;
    assign cnt_plus1         = sample_cnt + 16'd1;
    assign timeout           = (sample_cnt == MAX_PERIOD);

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= S_UNK;
        else
            state <= state_nxt;
    end

    // FSM next state: only accepted HIGH/LOW samples move it, timeout forgets it
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_UNK;
        end else if (accept_p0) begin
            case (state)
                S_UNK: begin
                    if (is_low_p0)       state_nxt = S_LOW;
                    else if (is_high_p0) state_nxt = S_HIGH;
                end
                S_LOW:   if (is_high_p0) state_nxt = S_HIGH;
                S_HIGH:  if (is_low_p0)  state_nxt = S_LOW;
                default: state_nxt = S_UNK;
            endcase
        end
    end

    // FSM outputs: rising crossing and how it is treated
    always_comb begin
        rise      = 1'b0;
        lock_acq  = 1'b0;
        period_ok = 1'b0;
        if (accept_p0 && !timeout && state == S_LOW && is_high_p0) begin
            rise      = 1'b1;
            lock_acq  = ~locked_p1;
            period_ok = locked_p1 && (cnt_plus1 >= MIN_PERIOD);
        end
    end

    assign counted = lock_acq | period_ok;

    // Sample counter and lock flag
    always_ff @(posedge CLOCK_50) begin
        if (reset || timeout) begin
            sample_cnt <= '0;
            locked_p1  <= 1'b0;
        end else if (accept_p0) begin
            sample_cnt <= counted ? '0 : sat_inc(sample_cnt);
            if (lock_acq)
                locked_p1 <= 1'b1;
        end
    end

`ifdef PITCH_AVG4_EN
    logic [CNT_W-1:0] hist [4];
    logic [17:0]      hist_sum;
    logic [17:0]      hist_sum_nxt;
    logic [2:0]       hist_fill;

    // Mean of four periods, fraction dropped
    function automatic logic [CNT_W-1:0] avg4_trunc(input logic [17:0] sum);
        return sum[17:2];
    endfunction

    // Oldest entry is zero until the window fills, so the running sum stays exact
    assign hist_sum_nxt = hist_sum + {2'b00, cnt_plus1} - {2'b00, hist[3]};
    assign report_ready = (hist_fill >= 3'd3);
    assign period_new   = avg4_trunc(hist_sum_nxt);

    // Four-entry period history with running sum
    always_ff @(posedge CLOCK_50) begin
        if (reset || timeout) begin
            for (int i = 0; i < 4; i++)
                hist[i] <= '0;
            hist_sum  <= '0;
            hist_fill <= '0;
        end else if (period_ok) begin
            hist[0] <= cnt_plus1;
            for (int i = 1; i < 4; i++)
                hist[i] <= hist[i-1];
            hist_sum <= hist_sum_nxt;
            if (hist_fill != 3'd4)
                hist_fill <= hist_fill + 3'd1;
        end
    end
`else
    assign report_ready = 1'b1;
    assign period_new   = cnt_plus1;
`endif

    // Stage p1: period register and one-cycle strobe
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            period_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (timeout) begin
                period_p1 <= '0;
                vld_p1    <= locked_p1;
            end else if (period_ok && report_ready) begin
                period_p1 <= period_new;
                vld_p1    <= 1'b1;
            end
        end
    end

    assign aud.period       = period_p1;
    assign aud.period_valid = vld_p1;
    assign aud.locked       = locked_p1;
endmodule

// File: tb/tb_audio_pitch_detector.sv
// tb_audio_pitch_detector: randomized and directed stimulus against a
// behavioural pitch model; every cycle the DUT outputs are compared to it.
// Build with PITCH_AVG4_EN defined to exercise the averaging variant.
module tb_audio_pitch_detector;
    localparam int HYST_V = 2000000;
    localparam int MIN_P  = 8;
    localparam int MAX_P  = 4800;
    localparam int AMP    = 10000000;

    logic CLOCK_50;
    logic reset;

    audio_pitch_if aud_if ();

    audio_pitch_detector #(
        .HYST       (32'sd2000000),
        .MIN_PERIOD (16'd8),
        .MAX_PERIOD (16'd4800)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .aud      (aud_if.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks;
    int n_errors;
    int n_strobes;

    // Reference model: polarity of the last decisive sample (-1/0/+1),
    // samples since the last counted crossing, lock, reported period.
    int m_pol;
    int m_since;
    bit m_locked;
    int m_period;
    bit m_pv;
    int raws[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_report(input int p);
`ifdef PITCH_AVG4_EN
        int s;
        raws.push_back(p);
        if (raws.size() > 4)
            void'(raws.pop_front());
        if (raws.size() == 4) begin
            s = 0;
            foreach (raws[i]) s += raws[i];
            m_period = s / 4;
            m_pv     = 1'b1;
        end
`else
        m_period = p;
        m_pv     = 1'b1;
`endif
    endtask

    task automatic model_step(input bit rst, input bit avail, input logic signed [31:0] s);
        bit hi;
        bit lo;
        bit rising;
        m_pv = 1'b0;
        if (rst) begin
            m_pol = 0; m_since = 0; m_locked = 0; m_period = 0;
            raws.delete();
        end else if (m_since == MAX_P) begin
            m_pv     = m_locked;
            m_period = 0; m_locked = 0; m_since = 0; m_pol = 0;
            raws.delete();
        end else if (avail) begin
            hi     = (s > HYST_V);
            lo     = (s < -HYST_V);
            rising = (m_pol < 0) && hi;
            if (hi)      m_pol = 1;
            else if (lo) m_pol = -1;
            if (rising && !m_locked) begin
                m_locked = 1;
                m_since  = 0;
            end else if (rising && (m_since + 1 >= MIN_P)) begin
                model_report(m_since + 1);
                m_since = 0;
            end else if (m_since < MAX_P) begin
                m_since++;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit avail, input logic signed [31:0] s);
        @(negedge CLOCK_50);
        reset                        = rst;
        aud_if.audio_in_available    = avail;
        aud_if.left_channel_audio_in = s;
        #1;
        check("read_audio_in", 64'(aud_if.read_audio_in), 64'(avail & ~rst));
        @(posedge CLOCK_50);
        model_step(rst, avail, s);
        #1;
        check("period_valid", 64'(aud_if.period_valid), 64'(m_pv));
        check("locked", 64'(aud_if.locked), 64'(m_locked));
        check("period", 64'(aud_if.period), 64'(m_period));
        if (aud_if.period_valid === 1'b1)
            n_strobes++;
    endtask

    // One accepted sample, preceded by gap-1 idle cycles carrying junk data
    task automatic feed(input logic signed [31:0] s, input int gap);
        for (int i = 1; i < gap; i++)
            cycle(1'b0, 1'b0, $urandom);
        cycle(1'b0, 1'b1, s);
    endtask

    // n periods, each a LOW half followed by a HIGH half
    task automatic square(input int n, input int hi_len, input int lo_len, input int gap, input int amp);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < lo_len; i++) feed(-amp, gap);
            for (int i = 0; i < hi_len; i++) feed(amp, gap);
        end
    endtask

    function automatic logic signed [31:0] pick(input int cls);
        int r;
        r = int'($urandom_range(0, 7));
        case (cls)
            1:       return (r == 0) ? HYST_V + 1 : HYST_V + 1 + int'($urandom_range(0, 500000000));
            -1:      return (r == 0) ? -HYST_V - 1 : -HYST_V - 1 - int'($urandom_range(0, 500000000));
            default: return (r == 0) ? HYST_V : (r == 1) ? -HYST_V :
                            int'($urandom_range(0, 2 * HYST_V)) - HYST_V;
        endcase
    endfunction

    int s0;

    initial begin
        n_checks = 0; n_errors = 0; n_strobes = 0;
        m_pol = 0; m_since = 0; m_locked = 0; m_period = 0; m_pv = 0;
        reset = 1'b1;
        aud_if.audio_in_available    = 1'b0;
        aud_if.left_channel_audio_in = '0;

        // Reset with a sample offered: it must not be consumed
        repeat (3) cycle(1'b1, 1'b1, 32'sd10000000);
        check("reset_locked", 64'(aud_if.locked), 64'd0);
        check("reset_period", 64'(aud_if.period), 64'd0);

        // Alternating inside the hysteresis band: never locks
        s0 = n_strobes;
        for (int i = 0; i < 40; i++)
            feed((i % 2) ? 1000000 : -1000000, 1);
        check("band_locked", 64'(aud_if.locked), 64'd0);
        check("band_strobes", 64'(n_strobes - s0), 64'd0);

        // 5/5 square wave, sample every cycle
        cycle(1'b1, 1'b0, 0);
        s0 = n_strobes;
        square(8, 5, 5, 1, AMP);
        check("sq_locked", 64'(aud_if.locked), 64'd1);
        check("sq_period", 64'(aud_if.period), 64'd10);
`ifdef PITCH_AVG4_EN
        check("sq_strobes", 64'(n_strobes - s0), 64'd4);
`else
        check("sq_strobes", 64'(n_strobes - s0), 64'd7);
`endif

        // Same wave, sample available one cycle in four
        cycle(1'b1, 1'b0, 0);
        square(6, 5, 5, 4, AMP);
        check("sparse_period", 64'(aud_if.period), 64'd10);

        // One-sample dip inside a HIGH half is rejected as a glitch
        for (int i = 0; i < 5; i++) feed(-AMP, 1);
        feed(AMP, 1); feed(AMP, 1);
        feed(-3000000, 1);
        feed(AMP, 1); feed(AMP, 1);
        square(1, 5, 5, 1, AMP);
        check("glitch_period", 64'(aud_if.period), 64'd10);
        check("glitch_locked", 64'(aud_if.locked), 64'd1);

        // Randomized segments: mixed lengths, gaps, boundary values, resets
        cycle(1'b1, 1'b0, 0);
        for (int seg = 0; seg < 80; seg++) begin
            int cls;
            int len;
            int gap;
            cls = (seg % 2 == 0) ? -1 : 1;
            if ($urandom_range(0, 5) == 0) cls = 0;
            len = int'($urandom_range(1, 12));
            gap = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0)
                    cycle(1'b1, 1'($urandom_range(0, 1)), pick(cls));
                else
                    feed(pick(cls), gap);
            end
        end

        // Silence after lock: exactly one zero-period strobe and loss of lock
        cycle(1'b1, 1'b0, 0);
        square(3, 5, 5, 1, AMP);
        s0 = n_strobes;
        repeat (MAX_P + 10) feed(0, 1);
        check("timeout_strobes", 64'(n_strobes - s0), 64'd1);
        check("timeout_locked", 64'(aud_if.locked), 64'd0);
        check("timeout_period", 64'(aud_if.period), 64'd0);

        // Reset in the middle of a period
        square(2, 5, 5, 1, AMP);
        square(3, 5, 5, 1, AMP);
        feed(-AMP, 1); feed(-AMP, 1); feed(-AMP, 1);
        cycle(1'b1, 1'b1, AMP);
        check("midrst_locked", 64'(aud_if.locked), 64'd0);
        check("midrst_period", 64'(aud_if.period), 64'd0);
        check("midrst_valid", 64'(aud_if.period_valid), 64'd0);

        // After reset a HIGH alone is not a crossing; LOW then HIGH is
        feed(AMP, 1); feed(AMP, 1); feed(AMP, 1);
        check("relock_wait", 64'(aud_if.locked), 64'd0);
        square(1, 1, 5, 1, AMP);
        check("relock", 64'(aud_if.locked), 64'd1);

`ifdef PITCH_AVG4_EN
        // Periods 10,10,12,12: first strobe after the fourth, mean 11
        cycle(1'b1, 1'b0, 0);
        square(1, 5, 5, 1, AMP);
        s0 = n_strobes;
        square(2, 5, 5, 1, AMP);
        square(1, 5, 7, 1, AMP);
        check("avg_early", 64'(n_strobes - s0), 64'd0);
        square(1, 5, 7, 1, AMP);
        check("avg_strobes", 64'(n_strobes - s0), 64'd1);
        check("avg_period", 64'(aud_if.period), 64'd11);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
